asp_net_tx: RTL

//   Network-side transmit stage of the ASP; it feeds the tagged-frame receive path.
//   It accepts one host data word, appends an integrity tag and presents the {data,tag} frame to the network.
//   It then waits for ACK and retransmits on timeout, up to a retry limit.
//   It reports success or failure to the host.

---
 rtl/asp_net_tx_if.sv | 28 ++
 rtl/asp_net_tx.sv | 120 ++++++++++++
 2 files changed

// File: rtl/asp_net_tx_if.sv
// Host and network handshake bundle for the ASP network transmit stage.
// The slave modport is the transmitter's view; master is the host/network side.
interface asp_net_tx_if #(
  parameter int unsigned data_size = 32,
  parameter int unsigned tag_size  = 8
);
  logic                          host_data_ready_in;
  logic [data_size-1:0]          host_data_in;
  logic                          host_busy_out;
  logic                          overrun_out;
  logic                          network_ACK_in;
  logic                          network_data_ready_out;
  logic [data_size+tag_size-1:0] network_data_tag_out;
  logic                          tx_done_out;
  logic                          tx_fail_out;

  modport master (
    output host_data_ready_in, host_data_in, network_ACK_in,
    input  host_busy_out, overrun_out, network_data_ready_out, network_data_tag_out,
    input  tx_done_out, tx_fail_out
  );

  modport slave (
    input  host_data_ready_in, host_data_in, network_ACK_in,
    output host_busy_out, overrun_out, network_data_ready_out, network_data_tag_out,
    output tx_done_out, tx_fail_out
  );
endinterface

// File: rtl/asp_net_tx.sv
// Network transmit stage: tags one host word, sends {data,tag}, waits for ACK and
// retransmits on timeout up to MAX_RETRY times, then reports done or fail.
module asp_net_tx #(
  parameter int unsigned           data_size   = 32,
  parameter int unsigned           tag_size    = 8,
  parameter logic [tag_size-1:0]   TAG_KEY     = 8'h8D,
  parameter int unsigned           ACK_TIMEOUT = 16,
  parameter int unsigned           MAX_RETRY   = 3
) (
  input logic            clk,
  input logic            reset,
  asp_net_tx_if.slave    bus
);

  localparam int unsigned FrameW = data_size + tag_size;
  localparam int unsigned TimerW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);

  typedef enum logic [1:0] {StIdle, StSend, StWaitAck} state_e;

  function automatic logic [tag_size-1:0] calc_tag(input logic [data_size-1:0] d);
    logic [tag_size-1:0] t;
    t = TAG_KEY;
    for (int unsigned i = 0; i < data_size / tag_size; i++) begin
      t ^= d[i*tag_size +: tag_size];
    end
    return t;
  endfunction

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RetryW-1:0]   retry_q, retry_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic                busy_q, busy_d;
  logic                over_q, over_d;
  logic                stb_q, stb_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    frame_d = frame_q;
    over_d  = 1'b0;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.host_data_ready_in) begin
          frame_d = {bus.host_data_in, calc_tag(bus.host_data_in)};
          retry_d = '0;
          stb_d   = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        over_d  = bus.host_data_ready_in;
        timer_d = '0;
        state_d = StWaitAck;
      end
      StWaitAck: begin
        over_d = bus.host_data_ready_in;
        // ACK takes priority over a coincident timeout
        if (bus.network_ACK_in) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (timer_q == TimerLast) begin
          if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            stb_d   = 1'b1;
            state_d = StSend;
          end else begin
            fail_d  = 1'b1;
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      retry_q <= '0;
      frame_q <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      stb_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      stb_q   <= stb_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.host_busy_out          = busy_q;
  assign bus.overrun_out            = over_q;
  assign bus.network_data_ready_out = stb_q;
  assign bus.network_data_tag_out   = frame_q;
  assign bus.tx_done_out            = done_q;
  assign bus.tx_fail_out            = fail_q;

endmodule
